// File: rtl/mccoy_pkg.sv
// mccoy_pkg: shared types and default sizes for the mccoy accumulator core.
// Optional feature: define MCCOY_HALT_EN to turn opcode 7 into HALT (otherwise DEC).
package mccoy_pkg;

    localparam int unsigned DATA_W_DEF = 6;
    localparam int unsigned NREGS_DEF  = 8;
    localparam int unsigned PC_W_DEF   = 6;

    typedef enum logic [2:0] {
        OpAdd  = 3'd0,
        OpAddi = 3'd1,
        OpLd   = 3'd2,
        OpSt   = 3'd3,
        OpLi   = 3'd4,
        OpBez  = 3'd5,
        OpJa   = 3'd6,
`ifdef MCCOY_HALT_EN
        OpHalt = 3'd7
`else
        OpDec  = 3'd7
`endif
    } opcode_e;

`ifdef MCCOY_HALT_EN
    typedef enum logic [1:0] {
        StFetch = 2'd0,
        StExec  = 2'd1,
        StHalt  = 2'd2
    } state_e;
`else
    typedef enum logic [0:0] {
        StFetch = 1'b0,
        StExec  = 1'b1
    } state_e;
`endif

endpackage

// File: rtl/mccoy_regfile.sv
// mccoy_regfile: NREGS x DATA_W register file, asynchronous read,
// one synchronous write port, asynchronous clear on reset_n.
module mccoy_regfile
    import mccoy_pkg::*;
#(
    parameter int unsigned  DATA_W = DATA_W_DEF,
    parameter int unsigned  NREGS  = NREGS_DEF,
    localparam int unsigned REG_AW = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [REG_AW-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [NREGS];

    // Storage: whole array clears on reset, one entry written per cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q <= '{default: '0};
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/mccoy_core_p.sv
// mccoy_core_p: two-cycle FETCH/EXEC accumulator core with an 8-opcode ISA,
// register file and registered debug mux.
// Optional feature: define MCCOY_HALT_EN to make opcode 7 HALT instead of DEC.
module mccoy_core_p
    import mccoy_pkg::*;
#(
    parameter int unsigned  DATA_W  = DATA_W_DEF,
    parameter int unsigned  NREGS   = NREGS_DEF,
    parameter int unsigned  PC_W    = PC_W_DEF,
    localparam int unsigned REG_AW  = $clog2(NREGS),
    localparam int unsigned INSTR_W = 3 + REG_AW
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic               dbg_sel,
    output logic [DATA_W-1:0]  dbg_o,
    output logic [PC_W-1:0]    pc_o,
    output logic [DATA_W-1:0]  acc_o,
    output logic               halted_o
);

    state_e             state_q, state_d;
    logic [INSTR_W-1:0] instr_q;
    logic [DATA_W-1:0]  acc_q, acc_d;
    logic [DATA_W-1:0]  dbg_q, dbg_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [PC_W-1:0]    pc_inc;
    logic [DATA_W-1:0]  rd_data;
    logic [DATA_W-1:0]  imm;
    logic [REG_AW-1:0]  a;
    opcode_e            op;
    logic               accept;
    logic               exec;
    logic               reg_we;

    assign op          = opcode_e'(instr_q[2:0]);
    assign a           = instr_q[INSTR_W-1:3];
    assign imm         = DATA_W'(a);
    assign pc_inc      = pc_q + PC_W'(1);
    // Ready is gated by reset_n so nothing is accepted while reset is held.
    assign instr_ready = (state_q == StFetch) & reset_n;
    assign accept      = instr_valid & instr_ready;
    assign exec        = (state_q == StExec);

    mccoy_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_regfile (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (reg_we),
        .waddr   (a),
        .wdata   (acc_q),
        .raddr   (a),
        .rdata   (rd_data)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: FETCH waits for a handshake, EXEC lasts one cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch: begin
                if (accept) begin
                    state_d = StExec;
                end
            end
            StExec: begin
                state_d = StFetch;
`ifdef MCCOY_HALT_EN
                if (op == OpHalt) begin
                    state_d = StHalt;
                end
`endif
            end
`ifdef MCCOY_HALT_EN
            StHalt:  state_d = StHalt;
`endif
            default: state_d = StFetch;
        endcase
    end

    // Datapath next state: everything commits only at the end of EXEC.
    always_comb begin
        acc_d  = acc_q;
        pc_d   = pc_q;
        reg_we = 1'b0;
        if (exec) begin
            pc_d = pc_inc;
            unique case (op)
                OpAdd:  acc_d = acc_q + rd_data;
                OpAddi: acc_d = acc_q + imm;
                OpLd:   acc_d = rd_data;
                OpSt:   reg_we = 1'b1;
                OpLi:   acc_d = imm;
                OpBez: begin
                    if (acc_q == '0) begin
                        pc_d = pc_q + PC_W'(imm);
                    end
                end
                OpJa:   pc_d = PC_W'(acc_q);
`ifdef MCCOY_HALT_EN
                OpHalt: pc_d = pc_inc;
`else
                OpDec:  acc_d = acc_q + {DATA_W{1'b1}};
`endif
                default: pc_d = pc_inc;
            endcase
        end
    end

    // Debug mux input, registered below for one cycle of latency.
    always_comb begin
        dbg_d = dbg_sel ? acc_q : DATA_W'(pc_q);
    end

    // Architectural state, instruction latch and debug register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instr_q <= '0;
            acc_q   <= '0;
            pc_q    <= '0;
            dbg_q   <= '0;
        end else begin
            if (accept) begin
                instr_q <= instr_i;
            end
            acc_q <= acc_d;
            pc_q  <= pc_d;
            dbg_q <= dbg_d;
        end
    end

    assign acc_o = acc_q;
    assign pc_o  = pc_q;
    assign dbg_o = dbg_q;

`ifdef MCCOY_HALT_EN
    assign halted_o = (state_q == StHalt);
`else
    assign halted_o = 1'b0;
`endif

endmodule

// File: tb/tb_mccoy_core_p.sv
// tb_mccoy_core_p: directed and randomized checks of mccoy_core_p against an
// instruction-level reference model (opcode 7 is HALT when MCCOY_HALT_EN is set).
module tb_mccoy_core_p;

    localparam int DW = 6;
    localparam int NR = 8;
    localparam int PW = 6;
    localparam int AW = 3;
    localparam int IW = 3 + AW;
    localparam int M  = 1 << DW;
    localparam int P  = 1 << PW;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [IW-1:0] instr_i = '0;
    logic          instr_valid = 1'b0;
    logic          instr_ready;
    logic          dbg_sel = 1'b0;
    logic [DW-1:0] dbg_o;
    logic [PW-1:0] pc_o;
    logic [DW-1:0] acc_o;
    logic          halted_o;

    int tests = 0;
    int fails = 0;

    // Reference model: architectural state plus "an instruction is pending".
    int m_acc, m_pc, m_dbg;
    int m_r[NR];
    bit m_busy, m_halted;
    int m_op, m_a;

    mccoy_core_p #(
        .DATA_W (DW),
        .NREGS  (NR),
        .PC_W   (PW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .instr_i     (instr_i),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .dbg_sel     (dbg_sel),
        .dbg_o       (dbg_o),
        .pc_o        (pc_o),
        .acc_o       (acc_o),
        .halted_o    (halted_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_acc = 0; m_pc = 0; m_dbg = 0;
        m_busy = 0; m_halted = 0;
        for (int i = 0; i < NR; i++) m_r[i] = 0;
    endtask

    task automatic model_exec();
        int imm;
        int nxt;
        imm = m_a % M;
        nxt = (m_pc + 1) % P;
        case (m_op)
            0: m_acc = (m_acc + m_r[m_a]) % M;
            1: m_acc = (m_acc + imm) % M;
            2: m_acc = m_r[m_a];
            3: m_r[m_a] = m_acc;
            4: m_acc = imm;
            5: if (m_acc == 0) nxt = (m_pc + imm) % P;
            6: nxt = m_acc % P;
            default: begin
`ifdef MCCOY_HALT_EN
                m_halted = 1;
`else
                m_acc = (m_acc + M - 1) % M;
`endif
            end
        endcase
        m_pc = nxt;
    endtask

    task automatic model_edge(input bit v, input int instr, input bit sel);
        m_dbg = sel ? m_acc : (m_pc % M);
        if (m_halted) begin
            // nothing accepted until reset
        end else if (m_busy) begin
            model_exec();
            m_busy = 0;
        end else if (v) begin
            m_op = instr % 8;
            m_a = instr / 8;
            m_busy = 1;
        end
    endtask

    function automatic int rnd_instr();
        int r;
        r = int'($urandom_range(0, (1 << IW) - 1));
`ifdef MCCOY_HALT_EN
        if (r % 8 == 7) r = r - 3;
`endif
        return r;
    endfunction

    // One clock cycle: drive, check ready, clock, then check all outputs.
    task automatic step(input bit v, input int instr);
        logic exp_ready;
        instr_valid = v;
        instr_i = IW'(instr);
        dbg_sel = 1'($urandom_range(0, 1));
        #1;
        exp_ready = !m_busy && !m_halted;
        tests++;
        if (instr_ready !== exp_ready) begin
            fails++;
            $display("FAIL ready: got %b want %b at %0t", instr_ready, exp_ready, $time);
        end
        @(posedge clk);
        model_edge(v, instr, dbg_sel);
        #1;
        tests++;
        if (int'(pc_o) !== m_pc) begin
            fails++;
            $display("FAIL pc: got %0d want %0d at %0t", pc_o, m_pc, $time);
        end
        tests++;
        if (int'(acc_o) !== m_acc) begin
            fails++;
            $display("FAIL acc: got %0d want %0d at %0t", acc_o, m_acc, $time);
        end
        tests++;
        if (int'(dbg_o) !== m_dbg) begin
            fails++;
            $display("FAIL dbg: got %0d want %0d at %0t", dbg_o, m_dbg, $time);
        end
        tests++;
        if (halted_o !== m_halted) begin
            fails++;
            $display("FAIL halted: got %b want %b at %0t", halted_o, m_halted, $time);
        end
    endtask

    // Issue one instruction: handshake cycle followed by its EXEC cycle.
    task automatic do_op(input int op, input int a);
        step(1'b1, a * 8 + op);
        step(1'($urandom_range(0, 1)), rnd_instr());
    endtask

    task automatic do_reset();
        instr_valid = 1'b1;
        reset_n = 1'b0;
        #1;
        model_reset();
        tests++;
        if (pc_o !== '0 || acc_o !== '0 || dbg_o !== '0 || halted_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_vals: pc=%0d acc=%0d dbg=%0d halted=%b want all 0",
                     pc_o, acc_o, dbg_o, halted_o);
        end
        tests++;
        if (instr_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_ready: got %b want 0", instr_ready);
        end
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        instr_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        // first handshake on the first edge after release
        step(1'b1, 3 * 8 + 4);
        tests++;
        if (instr_ready !== 1'b0) begin
            fails++;
            $display("FAIL first_handshake: ready got %b want 0 (EXEC)", instr_ready);
        end
        step(1'b0, 0);
    endtask

    task automatic test_li_addi();
        do_reset();
        do_op(4, 5);
        do_op(1, 3);
        tests++;
        if (acc_o !== DW'(8) || pc_o !== PW'(2)) begin
            fails++;
            $display("FAIL li_addi: acc=%0d pc=%0d want acc=8 pc=2", acc_o, pc_o);
        end
    endtask

    task automatic test_st_ld_dec();
        do_reset();
        do_op(4, 7);
        do_op(3, 2);
        do_op(4, 0);
        do_op(2, 2);
        tests++;
        if (acc_o !== DW'(7)) begin
            fails++;
            $display("FAIL st_ld: acc=%0d want 7", acc_o);
        end
`ifndef MCCOY_HALT_EN
        do_op(7, 0);
        tests++;
        if (acc_o !== DW'(6)) begin
            fails++;
            $display("FAIL dec: acc=%0d want 6", acc_o);
        end
`endif
    endtask

    task automatic test_bez();
        do_reset();
        do_op(4, 0);
        do_op(5, 4);
        tests++;
        if (pc_o !== PW'(5)) begin
            fails++;
            $display("FAIL bez_taken: pc=%0d want 5", pc_o);
        end
        do_op(4, 1);
        do_op(5, 4);
        tests++;
        if (pc_o !== PW'(7)) begin
            fails++;
            $display("FAIL bez_not_taken: pc=%0d want 7", pc_o);
        end
    endtask

    task automatic test_wrap_ja();
        do_reset();
        do_op(4, 7);
        do_op(3, 0);
        for (int i = 0; i < 8; i++) do_op(0, 0);
        do_op(6, 0);
        tests++;
        if (pc_o !== PW'(63)) begin
            fails++;
            $display("FAIL ja_63: pc=%0d want 63", pc_o);
        end
        do_op(4, 0);
        tests++;
        if (pc_o !== PW'(0)) begin
            fails++;
            $display("FAIL pc_wrap: pc=%0d want 0", pc_o);
        end
        do_op(4, 7);
        for (int i = 0; i < 8; i++) do_op(0, 0);
        do_op(1, 1);
        tests++;
        if (acc_o !== DW'(0)) begin
            fails++;
            $display("FAIL acc_wrap: acc=%0d want 0", acc_o);
        end
        do_op(4, 2);
        do_op(6, 0);
        tests++;
        if (pc_o !== PW'(2)) begin
            fails++;
            $display("FAIL ja_2: pc=%0d want 2", pc_o);
        end
    endtask

    task automatic test_reset_in_exec();
        do_reset();
        do_op(4, 4);
        step(1'b1, 3 * 8 + 1);  // ADDI 3 captured, core now in EXEC
        #2;
        reset_n = 1'b0;
        #1;
        tests++;
        if (acc_o !== '0 || pc_o !== '0) begin
            fails++;
            $display("FAIL reset_in_exec: acc=%0d pc=%0d want 0 0", acc_o, pc_o);
        end
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        instr_valid = 1'b0;
        model_reset();
        #1;
        tests++;
        if (instr_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_exec_fetch: ready=%b want 1", instr_ready);
        end
        step(1'b0, 0);
        step(1'b0, 0);
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 200; i++) step(1'b1, rnd_instr());
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 300; i++) step(1'($urandom_range(0, 1)), rnd_instr());
    endtask

`ifdef MCCOY_HALT_EN
    task automatic test_halt();
        do_reset();
        do_op(4, 3);
        do_op(7, 0);
        tests++;
        if (halted_o !== 1'b1 || pc_o !== PW'(2)) begin
            fails++;
            $display("FAIL halt_enter: halted=%b pc=%0d want 1 2", halted_o, pc_o);
        end
        for (int i = 0; i < 20; i++) step(1'b1, rnd_instr());
        tests++;
        if (instr_ready !== 1'b0 || pc_o !== PW'(2)) begin
            fails++;
            $display("FAIL halt_hold: ready=%b pc=%0d want 0 2", instr_ready, pc_o);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_li_addi();
        test_st_ld_dec();
        test_bez();
        test_wrap_ja();
        test_reset_in_exec();
        test_back_to_back();
        test_random();
`ifdef MCCOY_HALT_EN
        test_halt();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mccoy_core_p.md
MCCOY_CORE_P -- requirements
Module: mccoy_core_p

Interface
REQ-001 The block SHALL have one clock and one reset; reset is asynchronous and active-low.
REQ-002 Parameter DATA_W, default 6, SHALL set the accumulator (x8) and register width, range 4..16.
REQ-003 Parameter NREGS, default 8, SHALL set the register-file depth, power of two, range 2..32; REG_AW = clog2(NREGS).
REQ-004 Parameter PC_W, default 6, SHALL set the program-counter width, range 4..16.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset_n  input  1  asynchronous active-low reset.
REQ-007 instr_i  input  3+REG_AW  instruction: opcode [2:0], operand field a [3+REG_AW-1:3].
REQ-008 instr_valid  input  1  instr_i holds a valid instruction.
REQ-009 instr_ready  output  1  core can accept an instruction this cycle.
REQ-010 dbg_sel  input  1  debug mux select: 0 = PC, 1 = x8.
REQ-011 dbg_o  output  DATA_W  registered debug word; PC zero-extended or truncated to DATA_W.
REQ-012 pc_o  output  PC_W  current PC.
REQ-013 acc_o  output  DATA_W  current x8.
REQ-014 halted_o  output  1  core is in HALT.

Function
REQ-015 FSM states: FETCH, EXEC, HALT.
REQ-016 instr_ready SHALL be 1 only in FETCH with reset_n high.
REQ-017 The core SHALL capture instr_i on a rising edge with instr_valid & instr_ready, then go FETCH->EXEC; with no handshake it SHALL stay in FETCH with no state change.
REQ-018 EXEC SHALL commit x8, the register file and PC at the end of its single cycle, then return to FETCH. Throughput is one instruction per 2 cycles minimum.
REQ-019 Opcodes (a zero-extended to DATA_W as imm): 0 ADD x8+=R[a]; 1 ADDI x8+=imm; 2 LD x8=R[a]; 3 ST R[a]=x8; 4 LI x8=imm; 5 BEZ; 6 JA; 7 DEC x8+=all-ones.
REQ-020 All x8 arithmetic SHALL be modulo 2^DATA_W, with carry discarded.
REQ-021 BEZ: if x8==0, PC <= PC+imm (mod 2^PC_W); otherwise PC <= PC+1.
REQ-022 JA: PC <= x8, zero-extended or truncated to PC_W.
REQ-023 All other opcodes: PC <= PC+1, wrapping from 2^PC_W-1 to 0.
REQ-024 ST followed immediately by LD of the same register SHALL return the stored value.
REQ-025 dbg_o SHALL register the dbg_sel-selected value every cycle, giving one cycle of latency.

Reset
REQ-026 While reset_n is low: PC, x8, all NREGS registers, dbg_o and halted_o SHALL be 0, and the state SHALL be FETCH.
REQ-027 If reset asserts in EXEC, the pending instruction SHALL be discarded with no partial commit.
REQ-028 The first handshake SHALL be possible on the first rising edge after reset_n deasserts.

Configuration
REQ-029 When MCCOY_HALT_EN is defined, opcode 7 SHALL be HALT. In EXEC it SHALL set PC <= PC+1 and enter HALT, set halted_o=1 and hold instr_ready=0 until reset.
REQ-030 When MCCOY_HALT_EN is undefined, opcode 7 SHALL be DEC, the HALT state SHALL be absent, and halted_o SHALL be tied to 0.

Structure
REQ-031 Package mccoy_pkg SHALL hold the opcode enum, the FSM state enum and the DATA_W, NREGS and PC_W defaults.
REQ-032 Sub-module mccoy_regfile SHALL provide NREGS x DATA_W storage with asynchronous read, a single synchronous write port, and asynchronous clear on reset_n.

Verification
REQ-033 Reset, then LI 5, ADDI 3 -> acc_o=8, pc_o=2; instr_ready is high only in FETCH cycles.
REQ-034 LI 7, ST r2, LI 0, LD r2 -> acc_o=7; a following DEC gives acc_o=6 (HALT_EN undefined).
REQ-035 LI 0, then BEZ 4 at PC=1 -> pc_o=5; LI 1, then BEZ 4 -> pc_o=PC+1.
REQ-036 PC=63, LI 0 -> pc_o=0; x8=63, ADDI 1 -> acc_o=0; LI 2, JA -> pc_o=2.
REQ-037 Assert reset_n low in the EXEC cycle of ADDI 3 with x8=4 -> after release acc_o=0, pc_o=0, state FETCH.
REQ-038 With MCCOY_HALT_EN: opcode 7 -> halted_o=1, instr_ready=0 for 20 cycles under instr_valid=1, pc_o frozen at PC+1.
